// File: rtl/pcie_app_pkg.sv
// Shared PCIe application package: host register map indices and the
// C2F write sequencer state encoding.
package pcie_app_pkg;

    // Host register indices claimed by the C2F write sequencer
    localparam logic [7:0] C2FADDR     = 8'd253;
    localparam logic [7:0] C2FDATA_LSW = 8'd254;
    localparam logic [7:0] C2FDATA_MSW = 8'd255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LSW_HELD = 2'd1,
        ISSUE    = 2'd2
    } c2f_state_t;

endpackage : pcie_app_pkg

// File: rtl/c2f_write_seq.sv
// Assembles host 32-bit register writes (address, LSW, MSW) into 64-bit C2F writes.
// Optional macro C2F_AUTOINC_EN: post-increment the C2F address after each accepted beat.
module c2f_write_seq
    import pcie_app_pkg::*;
#(
    parameter int C2F_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      pcieClk_in,
    input  logic                      reset_in,
    input  logic                      cpuWrValid_in,
    input  logic [7:0]                cpuWrReg_in,
    input  logic [31:0]               cpuWrData_in,
    output logic                      c2fWrValid_out,
    input  logic                      c2fWrReady_in,
    output logic [C2F_ADDR_WIDTH-1:0] c2fWrAddr_out,
    output logic [63:0]               c2fWrData_out,
    input  logic                      clrErr_in,
    output logic                      busy_out,
    output logic                      seqErr_out,
    output logic                      overrun_out,
    output logic [CNT_WIDTH-1:0]      overrunCount_out
);

    c2f_state_t                state_r;
    logic [C2F_ADDR_WIDTH-1:0] addr_r;
    logic [31:0]               lsw_r;
    logic [31:0]               msw_r;
    logic                      valid_r;
    logic                      busy_r;
    logic                      seq_err_r;
    logic                      overrun_r;
    logic [CNT_WIDTH-1:0]      overrun_cnt_r;

    logic dec_addr_s;
    logic dec_lsw_s;
    logic dec_msw_s;
    logic dec_any_s;
    logic handshake_s;
    logic seq_err_evt_s;
    logic overrun_evt_s;

    // Address used for the next beat once the current one has been accepted
    function automatic logic [C2F_ADDR_WIDTH-1:0] addr_after_beat(
        input logic [C2F_ADDR_WIDTH-1:0] cur
    );
`ifdef C2F_AUTOINC_EN
        return cur + {{(C2F_ADDR_WIDTH-1){1'b0}}, 1'b1};
`else
        return cur;
`endif
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cur);
        if (&cur) begin
            return cur;
        end else begin
            return cur + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    // Register-index decode and error event detection
    always_comb begin
        dec_addr_s    = 1'b0;
        dec_lsw_s     = 1'b0;
        dec_msw_s     = 1'b0;
        if (cpuWrValid_in) begin
            dec_addr_s = (cpuWrReg_in == C2FADDR);
            dec_lsw_s  = (cpuWrReg_in == C2FDATA_LSW);
            dec_msw_s  = (cpuWrReg_in == C2FDATA_MSW);
        end else begin
            dec_addr_s = 1'b0;
            dec_lsw_s  = 1'b0;
            dec_msw_s  = 1'b0;
        end
        dec_any_s   = dec_addr_s | dec_lsw_s | dec_msw_s;
        handshake_s = (state_r == ISSUE) && c2fWrReady_in;
        // The handshake cycle behaves as IDLE, so an MSW there has no LSW to pair with
        seq_err_evt_s = dec_msw_s && ((state_r == IDLE) || handshake_s);
        overrun_evt_s = dec_any_s && (state_r == ISSUE) && !c2fWrReady_in;
    end

    // Sequencer FSM: collects address/LSW/MSW and holds the beat until accepted
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            state_r <= IDLE;
            addr_r  <= {C2F_ADDR_WIDTH{1'b0}};
            lsw_r   <= 32'd0;
            msw_r   <= 32'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, LSW_HELD: begin
                    if (dec_addr_s) begin
                        addr_r  <= cpuWrData_in[C2F_ADDR_WIDTH-1:0];
                        state_r <= IDLE;
                    end else if (dec_lsw_s) begin
                        lsw_r   <= cpuWrData_in;
                        state_r <= LSW_HELD;
                    end else if (dec_msw_s && (state_r == LSW_HELD)) begin
                        msw_r   <= cpuWrData_in;
                        state_r <= ISSUE;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ISSUE: begin
                    if (c2fWrReady_in) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        // An explicit address write beats the post-beat increment
                        if (dec_addr_s) begin
                            addr_r  <= cpuWrData_in[C2F_ADDR_WIDTH-1:0];
                            state_r <= IDLE;
                        end else begin
                            addr_r <= addr_after_beat(addr_r);
                            if (dec_lsw_s) begin
                                lsw_r   <= cpuWrData_in;
                                state_r <= LSW_HELD;
                            end else begin
                                state_r <= IDLE;
                            end
                        end
                    end else begin
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= ISSUE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error status; a same-cycle event takes priority over the clear
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            seq_err_r     <= 1'b0;
            overrun_r     <= 1'b0;
            overrun_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (seq_err_evt_s) begin
                seq_err_r <= 1'b1;
            end else if (clrErr_in) begin
                seq_err_r <= 1'b0;
            end else begin
                seq_err_r <= seq_err_r;
            end
            if (overrun_evt_s) begin
                overrun_r     <= 1'b1;
                overrun_cnt_r <= sat_inc(overrun_cnt_r);
            end else if (clrErr_in) begin
                overrun_r     <= 1'b0;
                overrun_cnt_r <= {CNT_WIDTH{1'b0}};
            end else begin
                overrun_r     <= overrun_r;
                overrun_cnt_r <= overrun_cnt_r;
            end
        end
    end

    assign c2fWrValid_out   = valid_r;
    assign c2fWrAddr_out    = addr_r;
    assign c2fWrData_out    = {msw_r, lsw_r};
    assign busy_out         = busy_r;
    assign seqErr_out       = seq_err_r;
    assign overrun_out      = overrun_r;
    assign overrunCount_out = overrun_cnt_r;

endmodule : c2f_write_seq

// File: tb/tb_c2f_write_seq.sv
// Directed self-checking bench for c2f_write_seq; honours C2F_AUTOINC_EN if defined.
module tb_c2f_write_seq;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        cpuWrValid_in;
    logic [7:0]  cpuWrReg_in;
    logic [31:0] cpuWrData_in;
    logic        c2fWrValid_out;
    logic        c2fWrReady_in;
    logic [9:0]  c2fWrAddr_out;
    logic [63:0] c2fWrData_out;
    logic        clrErr_in;
    logic        busy_out;
    logic        seqErr_out;
    logic        overrun_out;
    logic [7:0]  overrunCount_out;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int hs_snap;

    c2f_write_seq #(.C2F_ADDR_WIDTH(10), .CNT_WIDTH(8)) dut (
        .pcieClk_in       (clk),
        .reset_in         (reset_in),
        .cpuWrValid_in    (cpuWrValid_in),
        .cpuWrReg_in      (cpuWrReg_in),
        .cpuWrData_in     (cpuWrData_in),
        .c2fWrValid_out   (c2fWrValid_out),
        .c2fWrReady_in    (c2fWrReady_in),
        .c2fWrAddr_out    (c2fWrAddr_out),
        .c2fWrData_out    (c2fWrData_out),
        .clrErr_in        (clrErr_in),
        .busy_out         (busy_out),
        .seqErr_out       (seqErr_out),
        .overrun_out      (overrun_out),
        .overrunCount_out (overrunCount_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (c2fWrValid_out && c2fWrReady_in) hs_count <= hs_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents one host write for one posedge, returns at next negedge
    task automatic cpu_wr(input logic [7:0] idx, input logic [31:0] data);
        cpuWrValid_in = 1'b1;
        cpuWrReg_in   = idx;
        cpuWrData_in  = data;
        @(negedge clk);
        cpuWrValid_in = 1'b0;
    endtask

    task automatic clr_pulse();
        clrErr_in = 1'b1;
        @(negedge clk);
        clrErr_in = 1'b0;
    endtask

    initial begin
        reset_in      = 1'b1;
        cpuWrValid_in = 1'b0;
        cpuWrReg_in   = 8'd0;
        cpuWrData_in  = 32'd0;
        c2fWrReady_in = 1'b1;
        clrErr_in     = 1'b0;
        repeat (2) @(negedge clk);
        reset_in = 1'b0;

        check("rst_valid", {63'd0, c2fWrValid_out}, 64'd0);
        check("rst_busy",  {63'd0, busy_out}, 64'd0);
        check("rst_seqerr", {63'd0, seqErr_out}, 64'd0);
        check("rst_ovr",   {63'd0, overrun_out}, 64'd0);
        check("rst_cnt",   {56'd0, overrunCount_out}, 64'd0);
        check("rst_addr",  {54'd0, c2fWrAddr_out}, 64'd0);
        check("rst_data",  c2fWrData_out, 64'd0);

        // Basic beat with ready high
        cpu_wr(8'd253, 32'h0000_0010);
        cpu_wr(8'd254, 32'h1111_1111);
        cpu_wr(8'd255, 32'h2222_2222);
        check("b1_valid", {63'd0, c2fWrValid_out}, 64'd1);
        check("b1_busy",  {63'd0, busy_out}, 64'd1);
        check("b1_addr",  {54'd0, c2fWrAddr_out}, 64'h10);
        check("b1_data",  c2fWrData_out, 64'h2222_2222_1111_1111);
        @(negedge clk);
        check("b1_valid_1cyc", {63'd0, c2fWrValid_out}, 64'd0);
        check("b1_hs", 64'(hs_count), 64'd1);

        // Stall: ready low for five cycles, beat held for six
        cpu_wr(8'd253, 32'h0000_0040);
        c2fWrReady_in = 1'b0;
        cpu_wr(8'd254, 32'h3333_3333);
        cpu_wr(8'd255, 32'h4444_4444);
        for (int i = 0; i < 6; i++) begin
            check("st_valid", {63'd0, c2fWrValid_out}, 64'd1);
            check("st_addr",  {54'd0, c2fWrAddr_out}, 64'h40);
            check("st_data",  c2fWrData_out, 64'h4444_4444_3333_3333);
            if (i == 5) c2fWrReady_in = 1'b1;
            @(negedge clk);
        end
        check("st_valid_end", {63'd0, c2fWrValid_out}, 64'd0);
        check("st_hs", 64'(hs_count), 64'd2);

        // MSW from IDLE: sequence error, no beat
        hs_snap = hs_count;
        cpu_wr(8'd255, 32'h5555_5555);
        check("se_valid", {63'd0, c2fWrValid_out}, 64'd0);
        check("se_flag",  {63'd0, seqErr_out}, 64'd1);
        @(negedge clk);
        check("se_nohs", 64'(hs_count), 64'(hs_snap));
        clr_pulse();
        check("se_clr", {63'd0, seqErr_out}, 64'd0);
        // Event and clear in the same cycle: event wins
        clrErr_in = 1'b1;
        cpu_wr(8'd255, 32'h5555_5555);
        clrErr_in = 1'b0;
        check("se_win", {63'd0, seqErr_out}, 64'd1);
        clr_pulse();
        check("se_clr2", {63'd0, seqErr_out}, 64'd0);

        // Unrelated index is ignored
        cpu_wr(8'd254, 32'hAAAA_0001);
        cpu_wr(8'd100, 32'hBBBB_0002);
        cpu_wr(8'd255, 32'hCCCC_0003);
        check("ign_valid", {63'd0, c2fWrValid_out}, 64'd1);
        check("ign_data",  c2fWrData_out, 64'hCCCC_0003_AAAA_0001);
        @(negedge clk);

        // Handshake cycle with a simultaneous ADDR write: ADDR wins
        cpu_wr(8'd253, 32'h0000_0100);
        c2fWrReady_in = 1'b0;
        cpu_wr(8'd254, 32'h0000_0001);
        cpu_wr(8'd255, 32'h0000_0002);
        c2fWrReady_in = 1'b1;
        cpu_wr(8'd253, 32'h0000_0020);
        check("hsa_valid", {63'd0, c2fWrValid_out}, 64'd0);
        check("hsa_addr",  {54'd0, c2fWrAddr_out}, 64'h20);
        check("hsa_noovr", {63'd0, overrun_out}, 64'd0);

        // Handshake cycle with a simultaneous LSW write: held for the next beat
        c2fWrReady_in = 1'b0;
        cpu_wr(8'd254, 32'h0000_0003);
        cpu_wr(8'd255, 32'h0000_0004);
        c2fWrReady_in = 1'b1;
        cpu_wr(8'd254, 32'h0000_0077);
        cpu_wr(8'd255, 32'h0000_0088);
        check("hsl_valid", {63'd0, c2fWrValid_out}, 64'd1);
        check("hsl_data",  c2fWrData_out, 64'h0000_0088_0000_0077);
`ifdef C2F_AUTOINC_EN
        check("hsl_addr",  {54'd0, c2fWrAddr_out}, 64'h21);
`else
        check("hsl_addr",  {54'd0, c2fWrAddr_out}, 64'h20);
`endif
        @(negedge clk);

        // Overrun: 300 LSW writes while stalled
        c2fWrReady_in = 1'b0;
        cpu_wr(8'd254, 32'h0000_0001);
        cpu_wr(8'd255, 32'h0000_0002);
        for (int i = 0; i < 300; i++) begin
            cpu_wr(8'd254, 32'(i) + 32'h100);
            if (i == 2) check("ov_cnt3", {56'd0, overrunCount_out}, 64'd3);
        end
        check("ov_flag", {63'd0, overrun_out}, 64'd1);
        check("ov_sat",  {56'd0, overrunCount_out}, 64'd255);
        check("ov_hold", c2fWrData_out, 64'h0000_0002_0000_0001);
        check("ov_valid", {63'd0, c2fWrValid_out}, 64'd1);
        c2fWrReady_in = 1'b1;
        @(negedge clk);
        check("ov_done", {63'd0, c2fWrValid_out}, 64'd0);
        clr_pulse();
        check("ov_clr",  {63'd0, overrun_out}, 64'd0);
        check("ov_clr_cnt", {56'd0, overrunCount_out}, 64'd0);

        // Address wrap at the top of the space
        cpu_wr(8'd253, 32'h0000_03FF);
        cpu_wr(8'd254, 32'h0000_0011);
        cpu_wr(8'd255, 32'h0000_0012);
        check("wr_addr1", {54'd0, c2fWrAddr_out}, 64'h3FF);
        @(negedge clk);
        cpu_wr(8'd254, 32'h0000_0021);
        cpu_wr(8'd255, 32'h0000_0022);
`ifdef C2F_AUTOINC_EN
        check("wr_addr2", {54'd0, c2fWrAddr_out}, 64'h000);
`else
        check("wr_addr2", {54'd0, c2fWrAddr_out}, 64'h3FF);
`endif
        check("wr_data2", c2fWrData_out, 64'h0000_0022_0000_0021);
        @(negedge clk);

        // Reset while a beat is pending and errors are set
        c2fWrReady_in = 1'b0;
        cpu_wr(8'd253, 32'h0000_0055);
        cpu_wr(8'd255, 32'h0000_0000);
        cpu_wr(8'd254, 32'h0000_0001);
        cpu_wr(8'd255, 32'h0000_0002);
        cpu_wr(8'd254, 32'h0000_0009);
        check("pr_ovr", {63'd0, overrun_out}, 64'd1);
        check("pr_seq", {63'd0, seqErr_out}, 64'd1);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        check("ri_valid", {63'd0, c2fWrValid_out}, 64'd0);
        check("ri_busy",  {63'd0, busy_out}, 64'd0);
        check("ri_seq",   {63'd0, seqErr_out}, 64'd0);
        check("ri_ovr",   {63'd0, overrun_out}, 64'd0);
        check("ri_cnt",   {56'd0, overrunCount_out}, 64'd0);
        check("ri_addr",  {54'd0, c2fWrAddr_out}, 64'd0);
        // MSW right after reset must be a sequence error, proving IDLE
        cpu_wr(8'd255, 32'h0000_0003);
        check("ri_idle", {63'd0, seqErr_out}, 64'd1);
        check("ri_nobeat", {63'd0, c2fWrValid_out}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_c2f_write_seq

// File: doc/c2f_write_seq.md
C2F_WRITE_SEQ -- requirements
Module: c2f_write_seq

Interface
REQ-001 SHALL have parameter C2F_ADDR_WIDTH, default 10, width of the downstream C2F word address.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the saturating overrun counter.
REQ-003 SHALL have port pcieClk_in, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_in, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cpuWrValid_in, input, 1: host register-write strobe, one cycle per write.
REQ-006 SHALL have port cpuWrReg_in, input, 8: host register index.
REQ-007 SHALL have port cpuWrData_in, input, 32: host register write data.
REQ-008 SHALL have port c2fWrValid_out, output, 1: a downstream 64-bit write is offered.
REQ-009 SHALL have port c2fWrReady_in, input, 1: downstream accepts the offered write.
REQ-010 SHALL have port c2fWrAddr_out, output, C2F_ADDR_WIDTH: downstream word address.
REQ-011 SHALL have port c2fWrData_out, output, 64: downstream data, {MSW, LSW}.
REQ-012 SHALL have port clrErr_in, input, 1: clears all error status.
REQ-013 SHALL have port busy_out, output, 1: high while in state ISSUE.
REQ-014 SHALL have port seqErr_out, output, 1: sticky, MSW written with no LSW held.
REQ-015 SHALL have port overrun_out, output, 1: sticky, C2F register write dropped.
REQ-016 SHALL have port overrunCount_out, output, CNT_WIDTH: dropped-write count, saturating.

Function
REQ-017 SHALL decode only indices C2FADDR (253), C2FDATA_LSW (254) and C2FDATA_MSW (255); all other indices SHALL be ignored in every state.
REQ-018 SHALL implement the states IDLE, LSW_HELD and ISSUE.
REQ-019 SHALL handle a C2FADDR write in IDLE or LSW_HELD as: addrReg <= cpuWrData_in[C2F_ADDR_WIDTH-1:0], then go to IDLE, discarding any held LSW.
REQ-020 SHALL handle a C2FDATA_LSW write in IDLE or LSW_HELD as: lswReg <= data, then go to LSW_HELD; a repeat LSW SHALL overwrite the held value.
REQ-021 SHALL handle a C2FDATA_MSW write in LSW_HELD as: mswReg <= data, then go to ISSUE, so c2fWrValid_out rises on the next cycle (latency 1).
REQ-022 SHALL handle a C2FDATA_MSW write in IDLE by issuing no write, setting seqErr_out and staying in IDLE.
REQ-023 SHALL, in ISSUE, hold c2fWrValid_out high with c2fWrAddr_out and c2fWrData_out stable until the cycle in which c2fWrReady_in is high, then go to IDLE.
REQ-024 SHALL, in ISSUE, drop any decoded C2F write in cycles where c2fWrReady_in is low, setting overrun_out and incrementing overrunCount_out, which saturates at all-ones.
REQ-025 SHALL, in the handshake cycle, process a simultaneous decoded write as if in IDLE; a simultaneous C2FADDR write SHALL take precedence over auto-increment.
REQ-026 SHALL wrap the address modulo 2^C2F_ADDR_WIDTH.
REQ-027 SHALL, when clrErr_in is high, clear seqErr_out, overrun_out and overrunCount_out; a same-cycle error event SHALL win over the clear.
REQ-028 SHALL drive c2fWrAddr_out from addrReg in every state.

Reset
REQ-029 SHALL, with reset_in high at a clock edge, enter IDLE and zero addrReg, lswReg, mswReg, c2fWrValid_out, busy_out, seqErr_out, overrun_out and overrunCount_out.
REQ-030 SHALL, when reset occurs during ISSUE, abandon the pending write; c2fWrValid_out SHALL be low in the cycle after reset.

Configuration
REQ-031 SHALL, with macro C2F_AUTOINC_EN defined, increment addrReg by 1 on each completed handshake, except as overridden per REQ-025.
REQ-032 SHALL, without C2F_AUTOINC_EN, leave addrReg changed only by C2FADDR writes and reset.

Structure
REQ-033 SHALL take C2FADDR, C2FDATA_LSW and C2FDATA_MSW from the shared package pcie_app_pkg.
REQ-034 SHALL have the state enum typedef (c2f_state_t) added to pcie_app_pkg.
REQ-035 SHALL be a single module with no sub-module.

Verification
REQ-036 SHALL cover: ADDR=0x10, LSW=0x11111111, MSW=0x22222222, ready high -> one beat with addr 0x10, data 0x2222222211111111, valid high exactly one cycle.
REQ-037 SHALL cover: ready low for 5 cycles after issue -> valid, addr and data held stable for 6 cycles; one handshake occurs.
REQ-038 SHALL cover: MSW written from IDLE -> no beat issued and seqErr_out=1; clrErr_in pulse -> seqErr_out=0.
REQ-039 SHALL cover: 300 LSW writes while stalled in ISSUE -> overrun_out=1 and overrunCount_out=255 (saturated).
REQ-040 SHALL cover (C2F_AUTOINC_EN): ADDR=0x3FF then two LSW/MSW pairs -> beats at 0x3FF then 0x000; with the macro undefined, both beats at 0x3FF.
REQ-041 SHALL cover: reset_in asserted during ISSUE -> valid low next cycle; state IDLE; all status outputs zero.
